// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - iterative one-bit-per-clock shift/rotate engine
module iter_shifter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   d,
  output logic [WIDTH-1:0]   q,
  output logic               busy,
  output logic               done,
  output logic               ovf
);

  localparam logic [2:0] M_LOAD = 3'b000;
  localparam logic [2:0] M_SLL  = 3'b001;
  localparam logic [2:0] M_SRL  = 3'b010;
  localparam logic [2:0] M_SLA  = 3'b011;
  localparam logic [2:0] M_SRA  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ROR  = 3'b110;
  localparam logic [2:0] M_RSVD = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_q;
  logic [SHAMT_W-1:0] r_cnt;
  logic [2:0]         r_mode;
  logic               r_done;
  logic               r_ovf;

  logic               w_accept;
  logic               w_zero_len;
  logic               w_last;
  logic [WIDTH-1:0]   w_step_q;
  logic               w_step_ovf;

  // A request that has no steps to perform completes on its accept edge
  // without ever entering RUN.
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_zero_len = (shamt == '0) || (mode == M_LOAD) || (mode == M_RSVD);
  assign w_last     = (r_state == S_RUN) && (r_cnt == SHAMT_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: enter RUN on a non-trivial accept, leave on the last step.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !w_zero_len) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One step of the latched mode; overflow uses the pre-step top two bits.
  always_comb begin
    w_step_q   = r_q;
    w_step_ovf = r_ovf;
    case (r_mode)
      M_SLL: w_step_q = {r_q[WIDTH-2:0], 1'b0};
      M_SRL: w_step_q = {1'b0, r_q[WIDTH-1:1]};
      M_SLA: begin
        w_step_q   = {r_q[WIDTH-2:0], 1'b0};
        w_step_ovf = r_ovf | (r_q[WIDTH-1] ^ r_q[WIDTH-2]);
      end
      M_SRA: w_step_q = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
      M_ROL: w_step_q = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      M_ROR: w_step_q = {r_q[0], r_q[WIDTH-1:1]};
      default: w_step_q = r_q;
    endcase
  end

  // Datapath: latch operands on accept, step while running, pulse done once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      r_cnt  <= '0;
      r_mode <= M_LOAD;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_q    <= d;
        r_cnt  <= shamt;
        r_mode <= mode;
        r_ovf  <= 1'b0;
        r_done <= w_zero_len;
      end else if (r_state == S_RUN) begin
        r_q    <= w_step_q;
        r_ovf  <= w_step_ovf;
        r_cnt  <= r_cnt - SHAMT_W'(1);
        r_done <= w_last;
      end
    end
  end

  assign q    = r_q;
  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_iter_shifter.sv
// tb/tb_iter_shifter.sv - directed self-checking bench for iter_shifter
module tb_iter_shifter;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] mode;
  logic [3:0] shamt;
  logic [7:0] d;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  iter_shifter #(.WIDTH(8), .SHAMT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .shamt (shamt),
    .d     (d),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] m;
    logic [3:0] n;
    logic [7:0] dv;
    logic [7:0] eq;
    logic       eo;
    int         ebusy;
  } vec_t;

  // Issue one request from a negedge and follow it to completion.
  // Returns observations at the negedge after the last step, and one cycle later.
  task automatic do_op(input logic [2:0] m, input logic [3:0] n, input logic [7:0] dv,
                       output int bcyc, output logic [7:0] qf, output logic of,
                       output logic dn, output logic dn_after, output logic tmo);
    start = 1'b1; mode = m; shamt = n; d = dv;
    @(negedge clk);
    start = 1'b0;
    bcyc = 0;
    tmo = 1'b0;
    while (busy && bcyc < 40) begin
      bcyc++;
      @(negedge clk);
    end
    if (busy) tmo = 1'b1;
    qf = q; of = ovf; dn = done;
    @(negedge clk);
    dn_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mode = 3'b001; shamt = 4'd3; d = 8'h95;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({q, busy, done, ovf} !== 11'b0) begin
      errors++;
      $display("FAIL reset: q=%h busy=%b done=%b ovf=%b expected 00 0 0 0", q, busy, done, ovf);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({q, busy, done} !== 10'b0) begin
      errors++;
      $display("FAIL reset_idle: q=%h busy=%b done=%b expected 00 0 0", q, busy, done);
    end
  endtask

  task automatic test_vectors();
    vec_t tbl[$];
    int bcyc;
    logic [7:0] qf;
    logic of, dn, dna, tmo;
    tbl.push_back('{"sll3",   3'b001, 4'd3,  8'h95, 8'hA8, 1'b0, 3});
    tbl.push_back('{"srl2",   3'b010, 4'd2,  8'h95, 8'h25, 1'b0, 2});
    tbl.push_back('{"sra2",   3'b100, 4'd2,  8'h95, 8'hE5, 1'b0, 2});
    tbl.push_back('{"rol3",   3'b101, 4'd3,  8'h95, 8'hAC, 1'b0, 3});
    tbl.push_back('{"ror1",   3'b110, 4'd1,  8'h95, 8'hCA, 1'b0, 1});
    tbl.push_back('{"ror9",   3'b110, 4'd9,  8'h95, 8'hCA, 1'b0, 9});
    tbl.push_back('{"sll15",  3'b001, 4'd15, 8'h95, 8'h00, 1'b0, 15});
    tbl.push_back('{"sra15",  3'b100, 4'd15, 8'h95, 8'hFF, 1'b0, 15});
    tbl.push_back('{"sla1_ov",3'b011, 4'd1,  8'h95, 8'h2A, 1'b1, 1});
    tbl.push_back('{"sla1_ok",3'b011, 4'd1,  8'h35, 8'h6A, 1'b0, 1});
    tbl.push_back('{"sla2_ov",3'b011, 4'd2,  8'h35, 8'hD4, 1'b1, 2});
    tbl.push_back('{"load",   3'b000, 4'd7,  8'h95, 8'h95, 1'b0, 0});
    tbl.push_back('{"shamt0", 3'b001, 4'd0,  8'h95, 8'h95, 1'b0, 0});
    tbl.push_back('{"rsvd",   3'b111, 4'd5,  8'h95, 8'h95, 1'b0, 0});
    foreach (tbl[i]) begin
      do_op(tbl[i].m, tbl[i].n, tbl[i].dv, bcyc, qf, of, dn, dna, tmo);
      checks++;
      if (tmo) begin
        errors++;
        $display("FAIL %s_timeout: busy still high after %0d cycles, required low", tbl[i].name, bcyc);
      end
      checks++;
      if (bcyc !== tbl[i].ebusy) begin
        errors++;
        $display("FAIL %s_busy: busy cycles=%0d expected %0d", tbl[i].name, bcyc, tbl[i].ebusy);
      end
      checks++;
      if (qf !== tbl[i].eq) begin
        errors++;
        $display("FAIL %s_q: q=%h expected %h", tbl[i].name, qf, tbl[i].eq);
      end
      checks++;
      if (of !== tbl[i].eo) begin
        errors++;
        $display("FAIL %s_ovf: ovf=%b expected %b", tbl[i].name, of, tbl[i].eo);
      end
      checks++;
      if (dn !== 1'b1 || dna !== 1'b0) begin
        errors++;
        $display("FAIL %s_done: done=%b then %b expected 1 then 0", tbl[i].name, dn, dna);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    start = 1'b1; mode = 3'b001; shamt = 4'd1; d = 8'h95;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done: done=%b expected 1", done);
    end
    start = 1'b1; mode = 3'b010; shamt = 4'd1; d = 8'h95;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b expected 1 0", busy, done);
    end
    @(negedge clk);
    checks++;
    if (q !== 8'h4A || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result: q=%h done=%b busy=%b expected 4a 1 0", q, done, busy);
    end
    start = 1'b1; mode = 3'b000; shamt = 4'd3; d = 8'h33;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (q !== 8'h33 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_zero_len: q=%h done=%b busy=%b expected 33 1 0", q, done, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_interference();
    int n;
    start = 1'b1; mode = 3'b001; shamt = 4'd4; d = 8'h95;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; mode = 3'b110; shamt = 4'd9; d = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    n = 3;
    while (busy && n < 30) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (q !== 8'h50 || done !== 1'b1 || n !== 4) begin
      errors++;
      $display("FAIL interference: q=%h done=%b busy_cycles=%0d expected 50 1 4", q, done, n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int bcyc;
    logic [7:0] qf;
    logic of, dn, dna, tmo;
    logic saw_done;
    start = 1'b1; mode = 3'b101; shamt = 4'd6; d = 8'h95;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({q, busy, done, ovf} !== 11'b0) begin
      errors++;
      $display("FAIL reset_mid: q=%h busy=%b done=%b ovf=%b expected 00 0 0 0", q, busy, done, ovf);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet: activity=%b after abort expected 0", saw_done);
    end
    do_op(3'b010, 4'd2, 8'h95, bcyc, qf, of, dn, dna, tmo);
    checks++;
    if (qf !== 8'h25 || dn !== 1'b1 || bcyc !== 2 || tmo) begin
      errors++;
      $display("FAIL reset_mid_recover: q=%h done=%b busy_cycles=%0d expected 25 1 2", qf, dn, bcyc);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 3'b000; shamt = 4'd0; d = 8'h00;
    @(negedge clk);
    test_reset();
    test_vectors();
    test_back_to_back();
    test_interference();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iter_shifter.md
# iter_shifter

Parametrised, iterative shift/rotate engine: the multi-mode, multi-bit successor to the fixed 8-bit single-step shift registers. It latches an operand, a mode and a shift amount on a start strobe, then shifts one bit position per clock until the count is exhausted. It reports completion with a one-cycle `done` pulse and, for arithmetic-left shifts, a sticky overflow flag. It sits as a datapath helper beside the register file and ALU in the FF design area.

## Interface

Parameters:
- `WIDTH`, default 8: operand/result width in bits (≥ 2).
- `SHAMT_W`, default 4: width of the shift-amount input. The maximum count is 2^SHAMT_W − 1 and may exceed `WIDTH`.

Ports:
- `clk`, input, 1: the single clock, rising-edge active.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request strobe, accepted only when idle.
- `mode`, input, 3: operation select.
  - 000 LOAD, 001 SLL, 010 SRL, 011 SLA, 100 SRA, 101 ROL, 110 ROR.
  - 111 is reserved and behaves as LOAD.
- `shamt`, input, `SHAMT_W`: number of one-bit steps.
- `d`, input, `WIDTH`: operand.
- `q`, output, `WIDTH`: working/result register.
- `busy`, output, 1: high while steps remain.
- `done`, output, 1: one-cycle completion pulse.
- `ovf`, output, 1: sticky SLA overflow, valid while `done` = 1 and held until the next accept.

## Operation

- **States:** IDLE (`busy` = 0) and RUN (`busy` = 1).
- **Accept:** happens at an edge where the state is IDLE, `start` = 1 and `rst` = 0. On that edge:
  - `q` ← `d`.
  - Internal count ← `shamt`.
  - `mode` is latched; `ovf` ← 0.
  - If `shamt` = 0 or the mode is LOAD/reserved: stay in IDLE, `done` ← 1.
  - Otherwise: go to RUN.
- **RUN step (each edge):** apply one step of the latched mode to `q` and decrement the count. The edge that consumes the last step returns the state to IDLE and sets `done` ← 1.
- **Step definitions (W = `WIDTH`):**
  - SLL: `q` ← {q[W-2:0], 0}.
  - SRL: `q` ← {0, q[W-1:1]}.
  - SLA: `q` ← {q[W-2:0], 0}; `ovf` ← `ovf` | (q[W-1] ^ q[W-2]), using pre-step bits.
  - SRA: `q` ← {q[W-1], q[W-1:1]}.
  - ROL: `q` ← {q[W-2:0], q[W-1]}.
  - ROR: `q` ← {q[0], q[W-1:1]}.
- **Counts ≥ WIDTH:**
  - No clamping: the engine always performs exactly `shamt` steps.
  - SLL/SRL/SLA reach 0; SRA reaches all sign bits.
  - Rotates wrap modulo W in value, but still take `shamt` cycles.
- **`done`:** high for exactly one cycle after each completion, otherwise 0.
- **Input hold:** `d`, `mode` and `shamt` are ignored while in RUN, since operands are latched at accept. `start` while in RUN is ignored and not queued.
- **`q` after completion:** holds its value in IDLE until the next accept or reset.

## Timing

- **Reset:** with `rst` = 1 at an edge, the next state is `q` = 0, `busy` = 0, `done` = 0, `ovf` = 0, IDLE, count = 0.
  - Reset overrides `start` and any in-progress RUN; a mid-operation reset aborts with no `done`.
- **Latency:** accept at edge E0 with `shamt` = N > 0.
  - `busy` = 1 after E0.
  - Steps occur at E1..EN.
  - After EN: `busy` = 0, `done` = 1, and `q`/`ovf` hold final values.
  - Total is N + 1 edges from the accept edge to the result.
- **Zero-latency cases:** N = 0 or LOAD gives `q` = `d` and `done` = 1 after E0, with `busy` never asserted.
- **Back-to-back:** `start` = 1 in the cycle where `done` = 1 is accepted (state is IDLE). `done` drops on that edge unless the new request is itself zero-length.
- **Output registering:** `busy` is a direct state decode; `done`, `q` and `ovf` are registered.

## Test plan

Use WIDTH = 8, SHAMT_W = 4 and `d` = 8'b10010101 (0x95) unless noted.

- **SLL/SRL/SRA by small counts:**
  - SLL, `shamt` 3 → `busy` high 3 cycles, then `q` = 0xA8 with `done` = 1 for one cycle.
  - SRL 2 → 0x25.
  - SRA 2 → 0xE5.
- **Rotates and wrap:**
  - ROL 3 → 0xAC.
  - ROR 1 → 0xCA.
  - ROR 9 → 0xCA after 9 busy cycles.
  - SLL 15 → 0x00.
  - SRA 15 → 0xFF.
- **SLA overflow:**
  - 0x95, SLA 1 → `q` = 0x2A, `ovf` = 1.
  - `d` = 0x35, SLA 1 → `q` = 0x6A, `ovf` = 0.
  - `d` = 0x35, SLA 2 → `q` = 0xD4, `ovf` = 1; the flag must still be set at `done`.
- **Zero length and back-to-back:**
  - LOAD or `shamt` 0 → `q` = 0x95, `done` the next cycle, `busy` never high.
  - A new SRL 1 request issued in the `done` cycle is accepted → `q` = 0x4A two cycles later.
- **Interference:** SLL 4 in progress; pulse `start` with a different `d`/`mode` and change `shamt` at step 2 → ignored, final `q` = 0x50.
- **Reset mid-operation:**
  - Start ROL 6 and assert `rst` for one cycle at step 3 → next cycle `q` = 0, `busy` = 0, `done` = 0, `ovf` = 0, and no later `done`.
  - The next request then completes normally.
